// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the round-robin memory arbiter.
package mem_arb_pkg;

   // Transaction phases: pick a requester, drive the memory, acknowledge.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   localparam int DEF_NUM_CORES = 4;
   localparam int DEF_ADDR_W    = 32;
   localparam int DEF_DATA_W    = 32;

   // Width of a core index / round-robin pointer.
   function automatic int ptr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester at or after rr_ptr, wrapping.
module rr_pick
   import mem_arb_pkg::*;
#(
   parameter int NUM_CORES = DEF_NUM_CORES,
   localparam int CW       = ptr_width(NUM_CORES)
) (
   input  logic [NUM_CORES-1:0] req,
   input  logic [CW-1:0]        rr_ptr,
   output logic                 valid,
   output logic [CW-1:0]        winner
);

   logic [CW-1:0] idx;

   // Scan offsets from farthest to nearest so the nearest requester is assigned last and wins.
   always_comb begin
      // NOTE: every output and temporary gets a default before the loop so no path infers a latch.
      valid  = |req;
      winner = '0;
      idx    = '0;
      for (int k = NUM_CORES - 1; k >= 0; k--) begin
         idx = CW'((int'(rr_ptr) + k) % NUM_CORES);
         if (req[idx]) winner = idx;
      end
   end

endmodule

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one single-port memory among NUM_CORES cores.
// One transaction in flight; the command is latched at grant so requesters may
// change or drop their inputs without disturbing the access in progress.
module mem_rr_arbiter
   import mem_arb_pkg::*;
#(
   parameter int NUM_CORES = DEF_NUM_CORES,
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int DATA_W    = DEF_DATA_W,
   localparam int CW       = ptr_width(NUM_CORES)
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic [NUM_CORES-1:0]        core_req,
   input  logic [NUM_CORES-1:0]        core_we,
   input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
   input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
   output logic [NUM_CORES-1:0]        core_ack,
   output logic [DATA_W-1:0]           core_rdata,
   output logic [CW-1:0]               grant_id,
   output logic                        busy,
   output logic                        mem_read,
   output logic                        mem_write,
   output logic [ADDR_W-1:0]           mem_address,
   output logic [DATA_W-1:0]           mem_data_in,
   input  logic [DATA_W-1:0]           mem_data_out
);

   state_t              state;
   logic [CW-1:0]       rr_ptr;
   logic                we_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;

   logic                pick_valid;
   logic [CW-1:0]       pick_id;
   logic [CW-1:0]       next_ptr;

   rr_pick #(.NUM_CORES(NUM_CORES)) u_pick (
      .req    (core_req),
      .rr_ptr (rr_ptr),
      .valid  (pick_valid),
      .winner (pick_id)
   );

   // Pointer moves just past the core that was served, wrapping to core 0.
   assign next_ptr = (grant_id == CW'(NUM_CORES - 1)) ? '0 : grant_id + CW'(1);

   // Memory strobes only during ACCESS; a write is suppressed while reset is asserted
   // so an access interrupted by reset never commits.
   assign mem_read    = (state == ACCESS) && !we_q && reset_n;
   assign mem_write   = (state == ACCESS) &&  we_q && reset_n;
   assign mem_address = addr_q;
   assign mem_data_in = wdata_q;

   // Arbitration FSM with command latches, read-data capture and ack generation.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
         state      <= IDLE;
         rr_ptr     <= '0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         grant_id   <= '0;
         busy       <= 1'b0;
         core_ack   <= '0;
         core_rdata <= '0;
      end else begin
         core_ack <= '0;
         unique case (state)
            IDLE: begin
               if (pick_valid) begin
                  we_q     <= core_we[pick_id];
                  addr_q   <= core_addr[pick_id*ADDR_W +: ADDR_W];
                  wdata_q  <= core_wdata[pick_id*DATA_W +: DATA_W];
                  grant_id <= pick_id;
                  busy     <= 1'b1;
                  state    <= ACCESS;
               end
            end
            ACCESS: begin
               if (!we_q) core_rdata <= mem_data_out;
               core_ack[grant_id] <= 1'b1;
               state              <= RESP;
            end
            RESP: begin
               rr_ptr <= next_ptr;
               busy   <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
